// File: rtl/tt_um_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding,
// control/status bit positions on the bidirectional pins, and the pin direction mask.
package tt_um_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // uio_in control bits
   localparam int CTL_LOAD_A = 0;
   localparam int CTL_LOAD_B = 1;
   localparam int CTL_START  = 2;
   localparam int CTL_MODE   = 3;

   // uio_out status bits
   localparam int STS_BUSY  = 4;
   localparam int STS_DONE  = 5;
   localparam int STS_CARRY = 6;
   localparam int STS_OVF   = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_serial_adder_fa_cell.sv
// Single-bit combinational full adder used by the serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit operands, one bit per enabled clock,
// LSB first, with carry and signed-overflow flags published when the run completes.
module tt_um_serial_adder
   import tt_um_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int IDX_W = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   psum;
   logic [WIDTH-1:0]   result;
   logic [CNT_W-1:0]   cnt;
   logic               carry_run;
   logic               mode_run;
   logic               carry_flag;
   logic               ovf_flag;

   logic load_a, load_b, start, mode_in, any_load, accept;
   logic a_bit, b_bit, s_bit, co_bit, last_bit;
   logic unused_inputs;

   assign load_a   = uio_in[CTL_LOAD_A];
   assign load_b   = uio_in[CTL_LOAD_B];
   assign start    = uio_in[CTL_START];
   assign mode_in  = uio_in[CTL_MODE];
   assign any_load = load_a | load_b;
   assign accept   = (state == IDLE) || (state == DONE);
   assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

   assign unused_inputs = &{1'b0, uio_in[7:4], ui_in};

   // Subtraction is A + ~B + 1: the inversion happens per bit and the +1 is the initial carry.
   assign a_bit = op_a[cnt[IDX_W-1:0]];
   assign b_bit = op_b[cnt[IDX_W-1:0]] ^ mode_run;

   fa_cell u_fa (
      .a    (a_bit),
      .b    (b_bit),
      .cin  (carry_run),
      .sum  (s_bit),
      .cout (co_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (any_load) begin
               state_nxt = IDLE;
            end else if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a       <= '0;
         op_b       <= '0;
         psum       <= '0;
         result     <= '0;
         cnt        <= '0;
         carry_run  <= 1'b0;
         mode_run   <= 1'b0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
      end else if (ena) begin
         if (accept) begin
            if (load_a) begin
               op_a <= ui_in[WIDTH-1:0];
            end
            if (load_b) begin
               op_b <= ui_in[WIDTH-1:0];
            end
            if (!any_load && start) begin
               mode_run  <= mode_in;
               carry_run <= mode_in;
               cnt       <= '0;
               psum      <= '0;
            end
         end else if (state == RUN) begin
            // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
            psum      <= {s_bit, psum[WIDTH-1:1]};
            carry_run <= co_bit;
            cnt       <= cnt + 1'b1;
            if (last_bit) begin
               result     <= {s_bit, psum[WIDTH-1:1]};
               carry_flag <= co_bit;
               ovf_flag   <= carry_run ^ co_bit;
            end
         end
      end
   end

   assign uo_out  = 8'(result);
   assign uio_oe  = UIO_OE_VAL;

   always_comb begin
      uio_out            = 8'h00;
      uio_out[STS_BUSY]  = (state == RUN);
      uio_out[STS_DONE]  = (state == DONE);
      uio_out[STS_CARRY] = carry_flag;
      uio_out[STS_OVF]   = ovf_flag;
   end

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Bench for the serial adder: WIDTH=8 and WIDTH=4 instances share stimulus and are
// checked against an arithmetic reference model.
module tb_tt_um_serial_adder;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo8, uio_out8, oe8;
   logic [7:0] uo4, uio_out4, oe4;

   int tests = 0;
   int fails = 0;
   logic [7:0] cur_a = 8'h00;
   logic [7:0] cur_b = 8'h00;
   res_t prev8 = '0;
   res_t prev4 = '0;

   tt_um_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo8), .uio_out(uio_out8), .uio_oe(oe8)
   );

   tt_um_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo4), .uio_out(uio_out4), .uio_oe(oe4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic res_t model(input logic [7:0] a_in, input logic [7:0] b_in,
                                  input bit mode, input int w);
      res_t r;
      int unsigned mask, a, b, full;
      int sa, sb, exact;
      mask = (1 << w) - 1;
      a = a_in & mask;
      b = b_in & mask;
      sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
      sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
      if (mode) begin
         full  = a - b;
         exact = sa - sb;
         r.c   = (a >= b);
      end else begin
         full  = a + b;
         exact = sa + sb;
         r.c   = (full > mask);
      end
      r.res = 8'(full & mask);
      r.v   = (exact < -(1 << (w - 1))) || (exact > (1 << (w - 1)) - 1);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b);
      ui_in  = a;
      uio_in = 8'h01;
      tick();
      chk("load_clears_done8", uio_out8[5], 1'b0);
      chk("load_clears_done4", uio_out4[5], 1'b0);
      ui_in  = b;
      uio_in = 8'h02;
      tick();
      uio_in = 8'h00;
      cur_a  = a;
      cur_b  = b;
   endtask

   // inj: cycle at which an illegal load/start/mode pulse is driven mid-run.
   // hold_at/hold_len: window of cycles with ena held low.
   task automatic run_op(input bit mode, input int inj, input int hold_at, input int hold_len);
      res_t e8, e4;
      int cyc;
      e8 = model(cur_a, cur_b, mode, 8);
      e4 = model(cur_a, cur_b, mode, 4);
      uio_in = {4'b0000, mode, 3'b100};
      tick();
      uio_in = 8'h00;
      cyc = 0;
      for (int t = 1; t <= 12 + hold_len; t++) begin
         if (t == inj) begin
            ui_in  = 8'h00;
            uio_in = 8'h0F;
         end else begin
            uio_in = 8'h00;
         end
         ena = !(t >= hold_at && t < hold_at + hold_len);
         tick();
         if (ena) cyc++;
         chk("busy8", uio_out8[4], cyc < 8);
         chk("done8", uio_out8[5], cyc >= 8);
         chk("busy4", uio_out4[4], cyc < 4);
         chk("done4", uio_out4[5], cyc >= 4);
         chk("uo8", uo8, (cyc < 8) ? prev8.res : e8.res);
         chk("uo4", uo4, (cyc < 4) ? prev4.res : e4.res);
      end
      ena = 1'b1;
      chk("carry8", uio_out8[6], e8.c);
      chk("ovf8",   uio_out8[7], e8.v);
      chk("carry4", uio_out4[6], e4.c);
      chk("ovf4",   uio_out4[7], e4.v);
      chk("lo8",    uio_out8[3:0], 4'h0);
      chk("lo4",    uio_out4[3:0], 4'h0);
      prev8 = e8;
      prev4 = e4;
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      chk("rst_uo8",  uo8, 8'h00);
      chk("rst_uio8", uio_out8, 8'h00);
      chk("rst_oe8",  oe8, 8'hF0);
      chk("rst_uo4",  uo4, 8'h00);
      chk("rst_uio4", uio_out4, 8'h00);
      chk("rst_oe4",  oe4, 8'hF0);
      rst_n = 1'b1;
      tick();

      // Directed vectors
      load(8'h35, 8'h4A); run_op(1'b0, 0, 0, 0);
      chk("dir_35_4a", uo8, 8'h7F);
      load(8'hFF, 8'h01); run_op(1'b0, 0, 0, 0);
      chk("dir_ff_01", {uo8, uio_out8[7:6]}, {8'h00, 2'b01});
      load(8'h7F, 8'h01); run_op(1'b0, 0, 0, 0);
      chk("dir_7f_01", {uo8, uio_out8[7:6]}, {8'h80, 2'b10});
      load(8'h10, 8'h20); run_op(1'b1, 0, 0, 0);
      chk("dir_10_20", {uo8, uio_out8[7:6]}, {8'hF0, 2'b00});
      load(8'h80, 8'h01); run_op(1'b1, 0, 0, 0);
      chk("dir_80_01", {uo8, uio_out8[7]}, {8'h7F, 1'b1});
      load(8'h09, 8'h08); run_op(1'b0, 0, 0, 0);
      chk("dir4_9_8", {uo4, uio_out4[7:6]}, {8'h01, 2'b11});

      // ena frozen 3 cycles mid-run
      load(8'h09, 8'h08); run_op(1'b0, 0, 2, 3);
      chk("ena4_9_8", uo4, 8'h01);

      // Randomized operations
      for (int i = 0; i < 10; i++) begin
         load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         run_op(1'($urandom_range(0, 1)), 0, 0, 0);
      end

      // Load/start/mode pulse during RUN ignored; operands kept for a start-only rerun
      load(8'h35, 8'h4A); run_op(1'b0, 3, 0, 0);
      chk("inj_res8", uo8, 8'h7F);
      run_op(1'b0, 0, 0, 0);
      chk("rerun_res8", uo8, 8'h7F);

      // Asynchronous reset during RUN
      load(8'h5A, 8'h33);
      uio_in = 8'h04;
      tick();
      uio_in = 8'h00;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_uo8",  uo8, 8'h00);
      chk("arst_uio8", uio_out8, 8'h00);
      chk("arst_oe8",  oe8, 8'hF0);
      chk("arst_uo4",  uo4, 8'h00);
      chk("arst_uio4", uio_out4, 8'h00);
      tick(); tick();
      rst_n = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         chk("post_rst8", uio_out8, 8'h00);
         chk("post_rst4", uio_out4, 8'h00);
      end
      cur_a = 8'h00;
      cur_b = 8'h00;
      prev8 = '0;
      prev4 = '0;
      run_op(1'b0, 0, 0, 0);
      chk("cleared_ops8", uo8, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
